// File: rtl/adler32_chk_if.sv
// Stream/result bundle for the Adler-32 receive checker: data word handshake,
// reference trailer word and comparison outcome.
interface adler32_chk_if #(
    parameter int DATA_WD = 32
);
    logic               start_i;
    logic               val_i;
    logic               rdy_o;
    logic [DATA_WD-1:0] dat_i;
    logic               lst_i;
    logic [1:0]         lst_nb_i;
    logic               ref_val_i;
    logic [DATA_WD-1:0] ref_dat_i;
    logic               done_o;
    logic               pass_o;
    logic [DATA_WD-1:0] dat_o;

    modport master (
        output start_i, val_i, dat_i, lst_i, lst_nb_i, ref_val_i, ref_dat_i,
        input  rdy_o, done_o, pass_o, dat_o
    );

    modport slave (
        input  start_i, val_i, dat_i, lst_i, lst_nb_i, ref_val_i, ref_dat_i,
        output rdy_o, done_o, pass_o, dat_o
    );
endinterface

// File: rtl/adler32_chk.sv
// Receive-side Adler-32 checker: folds one byte per cycle of the decompressed
// stream and compares the running {s2,s1} against the zlib trailer word.
module adler32_chk #(
    parameter int DATA_WD    = 32,
    parameter int ADLER_BASE = 65521
) (
    input  logic         clk,
    input  logic         rst,
    adler32_chk_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACTV = 2'd1,
        PROC = 2'd2,
        CHK  = 2'd3
    } state_t;

    localparam logic [16:0] BASE17 = 17'(ADLER_BASE);
    localparam logic [17:0] BASE18 = 18'(ADLER_BASE);

    // One Adler-32 byte step; each sum needs only a single conditional subtract
    // because both inputs are already reduced below the modulus.
    function automatic logic [31:0] adler_fold(
        input logic [15:0] s1,
        input logic [15:0] s2,
        input logic [7:0]  b
    );
        logic [16:0] a1;
        logic [17:0] a2;
        a1 = {1'b0, s1} + {9'd0, b};
        if (a1 >= BASE17) begin
            a1 = a1 - BASE17;
        end else begin
            a1 = a1;
        end
        a2 = {2'b00, s2} + {2'b00, a1[15:0]};
        if (a2 >= BASE18) begin
            a2 = a2 - BASE18;
        end else begin
            a2 = a2;
        end
        return {a2[15:0], a1[15:0]};
    endfunction

    state_t             state_r;
    logic [15:0]        s1_r;
    logic [15:0]        s2_r;
    logic [DATA_WD-1:0] buf_r;
    logic [2:0]         rem_r;
    logic               last_r;
    logic               ref_got_r;
    logic [DATA_WD-1:0] ref_r;
    logic               rdy_r;
    logic               done_r;
    logic               pass_r;

    logic [7:0]         fold_byte_s;
    logic [31:0]        fold_s;
    logic               accept_s;
    logic [2:0]         nb_s;
    logic [DATA_WD-1:0] ref_eff_s;

    // Byte selection, fold result, accept strobe and effective reference.
    always_comb begin
        fold_byte_s = 8'd0;
        nb_s        = 3'd4;
        if (state_r == PROC) begin
            fold_byte_s = buf_r[31:24];
        end else begin
            fold_byte_s = bus.dat_i[31:24];
        end
        fold_s   = adler_fold(s1_r, s2_r, fold_byte_s);
        accept_s = rdy_r && bus.val_i;
        if (bus.lst_i) begin
            if (bus.lst_nb_i == 2'd0) begin
                nb_s = 3'd4;
            end else begin
                nb_s = {1'b0, bus.lst_nb_i};
            end
        end else begin
            nb_s = 3'd4;
        end
        if (ref_got_r) begin
            ref_eff_s = ref_r;
        end else begin
            ref_eff_s = bus.ref_dat_i;
        end
    end

    // Control FSM with checksum accumulators and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            s1_r      <= 16'd0;
            s2_r      <= 16'd0;
            buf_r     <= '0;
            rem_r     <= 3'd0;
            last_r    <= 1'b0;
            ref_got_r <= 1'b0;
            ref_r     <= '0;
            rdy_r     <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else if (bus.start_i) begin
            state_r   <= ACTV;
            s1_r      <= 16'd1;
            s2_r      <= 16'd0;
            ref_got_r <= 1'b0;
            rdy_r     <= 1'b1;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // First reference wins; later ones are ignored until restart.
            if ((state_r != IDLE) && bus.ref_val_i && !ref_got_r) begin
                ref_r     <= bus.ref_dat_i;
                ref_got_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    rdy_r <= 1'b0;
                end
                ACTV: begin
                    if (accept_s) begin
                        s1_r   <= fold_s[15:0];
                        s2_r   <= fold_s[31:16];
                        buf_r  <= {bus.dat_i[23:0], 8'd0};
                        rem_r  <= nb_s - 3'd1;
                        last_r <= bus.lst_i;
                        rdy_r  <= 1'b0;
                        if (nb_s == 3'd1) begin
                            state_r <= CHK;
                        end else begin
                            state_r <= PROC;
                        end
                    end
                end
                PROC: begin
                    s1_r  <= fold_s[15:0];
                    s2_r  <= fold_s[31:16];
                    buf_r <= {buf_r[23:0], 8'd0};
                    rem_r <= rem_r - 3'd1;
                    if (rem_r == 3'd1) begin
                        if (last_r) begin
                            state_r <= CHK;
                        end else begin
                            state_r <= ACTV;
                            rdy_r   <= 1'b1;
                        end
                    end
                end
                CHK: begin
                    if (ref_got_r || bus.ref_val_i) begin
                        done_r  <= 1'b1;
                        pass_r  <= (ref_eff_s == {s2_r, s1_r});
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rdy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdy_o  = rdy_r;
    assign bus.done_o = done_r;
    assign bus.pass_o = pass_r;
    assign bus.dat_o  = {s2_r, s1_r};

endmodule

// File: tb/tb_adler32_chk.sv
// Directed bench for adler32_chk: known Adler-32 vectors, modulo wrap,
// reference ordering, abort and reset behaviour.
module tb_adler32_chk;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   done_cnt;
    int   inv_bad;
    int   base_cnt;

    adler32_chk_if bus_if ();

    adler32_chk dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.done_o) done_cnt++;
        if (bus_if.dat_o[15:0] >= 16'd65521 || bus_if.dat_o[31:16] >= 16'd65521) inv_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] nb,
                             input logic rv, input logic [31:0] rd);
        int t;
        t = 0;
        while (bus_if.rdy_o !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        chk("rdy_wait", {31'd0, bus_if.rdy_o}, 32'd1);
        bus_if.val_i     = 1'b1;
        bus_if.dat_i     = d;
        bus_if.lst_i     = l;
        bus_if.lst_nb_i  = nb;
        bus_if.ref_val_i = rv;
        bus_if.ref_dat_i = rd;
        tick();
        bus_if.val_i     = 1'b0;
        bus_if.lst_i     = 1'b0;
        bus_if.lst_nb_i  = 2'd0;
        bus_if.ref_val_i = 1'b0;
    endtask

    task automatic do_start();
        bus_if.start_i = 1'b1;
        tick();
        bus_if.start_i = 1'b0;
    endtask

    task automatic send_ref(input logic [31:0] rd);
        bus_if.ref_val_i = 1'b1;
        bus_if.ref_dat_i = rd;
        tick();
        bus_if.ref_val_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; done_cnt = 0; inv_bad = 0; base_cnt = 0;
        rst = 1'b1;
        bus_if.start_i = 1'b0; bus_if.val_i = 1'b0; bus_if.dat_i = 32'd0;
        bus_if.lst_i = 1'b0; bus_if.lst_nb_i = 2'd0;
        bus_if.ref_val_i = 1'b0; bus_if.ref_dat_i = 32'd0;
        tick(); tick();
        chk("rst_rdy", {31'd0, bus_if.rdy_o}, 32'd0);
        chk("rst_done", {31'd0, bus_if.done_o}, 32'd0);
        chk("rst_pass", {31'd0, bus_if.pass_o}, 32'd0);
        chk("rst_dat", bus_if.dat_o, 32'h0000_0000);
        rst = 1'b0;
        tick();

        // "abc" with the reference delivered before the data
        do_start();
        chk("start_rdy", {31'd0, bus_if.rdy_o}, 32'd1);
        chk("start_dat", bus_if.dat_o, 32'h0000_0001);
        send_ref(32'h024D_0127);
        send_word(32'h6162_6300, 1'b1, 2'd3, 1'b0, 32'd0);
        tick(); tick();
        chk("abc_done_early", {31'd0, bus_if.done_o}, 32'd0);
        tick();
        chk("abc_done", {31'd0, bus_if.done_o}, 32'd1);
        chk("abc_pass", {31'd0, bus_if.pass_o}, 32'd1);
        chk("abc_dat", bus_if.dat_o, 32'h024D_0127);
        tick();
        chk("abc_done_pulse", {31'd0, bus_if.done_o}, 32'd0);
        chk("abc_pass_hold", {31'd0, bus_if.pass_o}, 32'd1);

        // "Wikipedia", reference after the data, rdy_o gaps checked
        do_start();
        send_word(32'h5769_6B69, 1'b0, 2'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("wiki_rdy_low0", {31'd0, bus_if.rdy_o}, 32'd0);
            tick();
        end
        chk("wiki_rdy_back0", {31'd0, bus_if.rdy_o}, 32'd1);
        send_word(32'h7065_6469, 1'b0, 2'd0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("wiki_rdy_low1", {31'd0, bus_if.rdy_o}, 32'd0);
            tick();
        end
        send_word(32'h6100_0000, 1'b1, 2'd1, 1'b0, 32'd0);
        tick(); tick();
        chk("wiki_wait_ref", {31'd0, bus_if.done_o}, 32'd0);
        send_ref(32'h11E6_0398);
        chk("wiki_done", {31'd0, bus_if.done_o}, 32'd1);
        chk("wiki_pass", {31'd0, bus_if.pass_o}, 32'd1);
        chk("wiki_dat", bus_if.dat_o, 32'h11E6_0398);

        // same stream, wrong reference
        do_start();
        send_word(32'h5769_6B69, 1'b0, 2'd0, 1'b0, 32'd0);
        send_word(32'h7065_6469, 1'b0, 2'd0, 1'b0, 32'd0);
        send_word(32'h6100_0000, 1'b1, 2'd1, 1'b0, 32'd0);
        send_ref(32'h11E6_0399);
        chk("bad_done", {31'd0, bus_if.done_o}, 32'd1);
        chk("bad_pass", {31'd0, bus_if.pass_o}, 32'd0);
        chk("bad_dat", bus_if.dat_o, 32'h11E6_0398);

        // 257 bytes of 0xFF: s1 wraps to 15
        do_start();
        inv_bad = 0;
        for (int i = 0; i < 64; i++) send_word(32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0, 32'd0);
        send_word(32'hFF00_0000, 1'b1, 2'd1, 1'b1, 32'h080F_000F);
        tick();
        chk("wrap_done", {31'd0, bus_if.done_o}, 32'd1);
        chk("wrap_pass", {31'd0, bus_if.pass_o}, 32'd1);
        chk("wrap_dat", bus_if.dat_o, 32'h080F_000F);
        chk("wrap_invariant", inv_bad, 32'd0);

        // random gaps, reference with last byte, then a second wrong reference
        do_start();
        base_cnt = done_cnt;
        repeat ($urandom_range(0, 3)) tick();
        send_word(32'h5769_6B69, 1'b0, 2'd0, 1'b0, 32'd0);
        repeat ($urandom_range(0, 5)) tick();
        send_word(32'h7065_6469, 1'b0, 2'd0, 1'b0, 32'd0);
        repeat ($urandom_range(0, 5)) tick();
        send_word(32'h6100_0000, 1'b1, 2'd1, 1'b1, 32'h11E6_0398);
        send_ref(32'h11E6_0399);
        chk("first_ref_done", {31'd0, bus_if.done_o}, 32'd1);
        chk("first_ref_pass", {31'd0, bus_if.pass_o}, 32'd1);
        repeat (5) tick();
        chk("single_done", done_cnt - base_cnt, 32'd1);

        // start_i during PROC aborts without done_o
        do_start();
        base_cnt = done_cnt;
        send_ref(32'h024D_0127);
        send_word(32'h5769_6B69, 1'b0, 2'd0, 1'b0, 32'd0);
        do_start();
        chk("abort_dat", bus_if.dat_o, 32'h0000_0001);
        chk("abort_rdy", {31'd0, bus_if.rdy_o}, 32'd1);

        // rst mid-stream
        send_word(32'h6162_6300, 1'b0, 2'd0, 1'b1, 32'h024D_0127);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_dat", bus_if.dat_o, 32'h0000_0000);
        chk("mid_rst_rdy", {31'd0, bus_if.rdy_o}, 32'd0);
        chk("mid_rst_pass", {31'd0, bus_if.pass_o}, 32'd0);
        repeat (10) tick();
        chk("no_done_abort", done_cnt - base_cnt, 32'd0);

        // recovery: "abc" passes again
        do_start();
        send_word(32'h6162_6300, 1'b1, 2'd3, 1'b1, 32'h024D_0127);
        tick(); tick(); tick();
        chk("rec_done", {31'd0, bus_if.done_o}, 32'd1);
        chk("rec_pass", {31'd0, bus_if.pass_o}, 32'd1);
        chk("rec_dat", bus_if.dat_o, 32'h024D_0127);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
